// File: rtl/procc_operand_reader.sv
// rtl/procc_operand_reader.sv - operand RAM read side: fetch opa/opb pairs, apply opcode, stream results
//
// Purpose:
//   On procc_start (ignored while busy) latches a 3-bit opcode and a pair
//   count, then walks the operand RAM from address 0 up to length-1. Each pair
//   is combined by the opcode and the result is offered on a valid/ready
//   handshake. ACC folds every pair into one running sum and emits it once.
//   procc_done pulses for one cycle when the run completes.
//
// Ports:
//   pu_clk, pu_reset            clock, synchronous active-high reset
//   procc_start                 run request; pu_instruction, pu_data_length sampled with it
//   pu_address_mem_opa/opb      registered RAM read address (identical)
//   mem_data_out_opa/opb        RAM read data, one cycle after the address
//   pu_result, pu_result_flag   result word and carry/borrow/compare/saturate flag
//   pu_result_valid/ready       result handshake
//   pu_busy                     high whenever the FSM is not idle
//   procc_done                  one-cycle end-of-run pulse
//
// Build option:
//   PROCC_SATURATE_EN  ADD/ACC clamp to all-ones on carry, SUB clamps to 0 on
//                      borrow; the flag then means "saturated".

module procc_operand_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              pu_clk,
  input  logic              pu_reset,
  input  logic              procc_start,
  input  logic [2:0]        pu_instruction,
  input  logic [ADDR_W-1:0] pu_data_length,
  output logic [ADDR_W-1:0] pu_address_mem_opa,
  output logic [ADDR_W-1:0] pu_address_mem_opb,
  input  logic [DATA_W-1:0] mem_data_out_opa,
  input  logic [DATA_W-1:0] mem_data_out_opb,
  output logic [DATA_W-1:0] pu_result,
  output logic              pu_result_flag,
  output logic              pu_result_valid,
  input  logic              pu_result_ready,
  output logic              pu_busy,
  output logic              procc_done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MIN = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              acc_flag_q, acc_flag_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              flag_q, flag_d;

  // Datapath
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] sub_diff;
  logic              a_lt_b;
  logic [DATA_W+1:0] acc_full;
  logic              acc_carry;
  logic [DATA_W-1:0] alu_res;
  logic              alu_flag;
  logic [DATA_W-1:0] acc_next;
  logic              acc_flag_next;
  logic              last_pair;

  assign add_full  = {1'b0, mem_data_out_opa} + {1'b0, mem_data_out_opb};
  assign sub_diff  = mem_data_out_opa - mem_data_out_opb;
  assign a_lt_b    = mem_data_out_opa < mem_data_out_opb;
  // Three-operand sum; any bit above DATA_W means a carry happened either in
  // the pair sum or when folding it into the accumulator.
  assign acc_full  = {2'b00, acc_q} + {2'b00, mem_data_out_opa} + {2'b00, mem_data_out_opb};
  assign acc_carry = |acc_full[DATA_W+1:DATA_W];
  assign last_pair = (idx_q == len_q - ADDR_W'(1));

  always_comb begin
    alu_res       = '0;
    alu_flag      = 1'b0;
    acc_flag_next = acc_flag_q | acc_carry;
`ifdef PROCC_SATURATE_EN
    // Sticky: once saturated the sum stays pinned at all-ones.
    acc_next = acc_flag_next ? {DATA_W{1'b1}} : acc_full[DATA_W-1:0];
`else
    acc_next = acc_full[DATA_W-1:0];
`endif
    case (op_q)
      OP_ADD: begin
`ifdef PROCC_SATURATE_EN
        alu_res = add_full[DATA_W] ? {DATA_W{1'b1}} : add_full[DATA_W-1:0];
`else
        alu_res = add_full[DATA_W-1:0];
`endif
        alu_flag = add_full[DATA_W];
      end
      OP_SUB: begin
`ifdef PROCC_SATURATE_EN
        alu_res = a_lt_b ? '0 : sub_diff;
`else
        alu_res = sub_diff;
`endif
        alu_flag = a_lt_b;
      end
      OP_AND: alu_res = mem_data_out_opa & mem_data_out_opb;
      OP_OR:  alu_res = mem_data_out_opa | mem_data_out_opb;
      OP_XOR: alu_res = mem_data_out_opa ^ mem_data_out_opb;
      OP_MIN: begin
        alu_res  = a_lt_b ? mem_data_out_opa : mem_data_out_opb;
        alu_flag = a_lt_b;
      end
      OP_MAX: begin
        alu_res  = a_lt_b ? mem_data_out_opb : mem_data_out_opa;
        alu_flag = a_lt_b;
      end
      default: begin
        alu_res  = acc_next;
        alu_flag = acc_flag_next;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    acc_flag_d = acc_flag_q;
    res_d      = res_q;
    flag_d     = flag_q;
    case (state_q)
      S_IDLE: begin
        if (procc_start) begin
          op_d       = pu_instruction;
          len_d      = pu_data_length;
          idx_d      = '0;
          addr_d     = '0;
          acc_d      = '0;
          acc_flag_d = 1'b0;
          state_d    = (pu_data_length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (op_q == OP_ACC) begin
          acc_d      = acc_next;
          acc_flag_d = acc_flag_next;
          if (last_pair) begin
            res_d   = alu_res;
            flag_d  = alu_flag;
            state_d = S_EMIT;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            addr_d  = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          res_d   = alu_res;
          flag_d  = alu_flag;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (pu_result_ready) begin
          if (last_pair) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            addr_d  = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pu_clk) begin
    if (pu_reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      acc_flag_q <= 1'b0;
      res_q      <= '0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      acc_flag_q <= acc_flag_d;
      res_q      <= res_d;
      flag_q     <= flag_d;
    end
  end

  assign pu_address_mem_opa = addr_q;
  assign pu_address_mem_opb = addr_q;
  assign pu_result          = res_q;
  assign pu_result_flag     = flag_q;
  assign pu_result_valid    = (state_q == S_EMIT);
  assign pu_busy            = (state_q != S_IDLE);
  assign procc_done         = (state_q == S_DONE);

endmodule

// File: tb/tb_procc_operand_reader.sv
// tb/tb_procc_operand_reader.sv - directed self-checking bench for procc_operand_reader

module tb_procc_operand_reader;

  localparam int DW = 32;
  localparam int AW = 6;

  logic          pu_clk = 1'b0;
  logic          pu_reset;
  logic          procc_start;
  logic [2:0]    pu_instruction;
  logic [AW-1:0] pu_data_length;
  logic [AW-1:0] pu_address_mem_opa;
  logic [AW-1:0] pu_address_mem_opb;
  logic [DW-1:0] mem_data_out_opa;
  logic [DW-1:0] mem_data_out_opb;
  logic [DW-1:0] pu_result;
  logic          pu_result_flag;
  logic          pu_result_valid;
  logic          pu_result_ready;
  logic          pu_busy;
  logic          procc_done;

  procc_operand_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .pu_clk             (pu_clk),
    .pu_reset           (pu_reset),
    .procc_start        (procc_start),
    .pu_instruction     (pu_instruction),
    .pu_data_length     (pu_data_length),
    .pu_address_mem_opa (pu_address_mem_opa),
    .pu_address_mem_opb (pu_address_mem_opb),
    .mem_data_out_opa   (mem_data_out_opa),
    .mem_data_out_opb   (mem_data_out_opb),
    .pu_result          (pu_result),
    .pu_result_flag     (pu_result_flag),
    .pu_result_valid    (pu_result_valid),
    .pu_result_ready    (pu_result_ready),
    .pu_busy            (pu_busy),
    .procc_done         (procc_done)
  );

  always #5 pu_clk = ~pu_clk;

  // Operand RAM with 1-cycle synchronous read
  logic [DW-1:0] ram_a [0:63];
  logic [DW-1:0] ram_b [0:63];
  always @(posedge pu_clk) begin
    mem_data_out_opa <= ram_a[pu_address_mem_opa];
    mem_data_out_opb <= ram_b[pu_address_mem_opb];
  end

  // Output monitor, sampled on the falling edge
  logic [DW-1:0] res_q[$];
  logic          flg_q[$];
  int            hs_cyc[$];
  int            ncyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            both_cnt = 0;
  always @(negedge pu_clk) begin
    ncyc = ncyc + 1;
    if (pu_result_valid && pu_result_ready) begin
      res_q.push_back(pu_result);
      flg_q.push_back(pu_result_flag);
      hs_cyc.push_back(ncyc);
    end
    if (procc_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = ncyc;
    end
    if (procc_done && pu_result_valid) both_cnt = both_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pu_clk);
    #1;
  endtask

  // Raise start now; it is sampled on the next edge, after which the bench
  // sits in the first cycle following that edge (E+1).
  task automatic start_run(input logic [2:0] op, input logic [AW-1:0] len);
    procc_start    = 1'b1;
    pu_instruction = op;
    pu_data_length = len;
    tick();
    procc_start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int max);
    int k;
    k = 0;
    while (done_cnt == base && k < max) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, (done_cnt != base), 1'b1);
  endtask

  task automatic run1(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] er, input logic ef);
    int rb, db;
    rb = res_q.size();
    db = done_cnt;
    ram_a[0] = a;
    ram_b[0] = b;
    start_run(op, 1);
    wait_done(tag, db, 50);
    check({tag, "_cnt"}, res_q.size() - rb, 1);
    if (res_q.size() > rb) begin
      check({tag, "_res"}, res_q[rb], er);
      check({tag, "_flag"}, flg_q[rb], ef);
    end
  endtask

  int rb, db, hb, k;
  logic [DW-1:0] exp_sub, exp_add;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
    pu_reset        = 1'b1;
    procc_start     = 1'b0;
    pu_instruction  = 3'b000;
    pu_data_length  = '0;
    pu_result_ready = 1'b1;
    tick(); tick(); tick();

    // Reset state
    check("rst_result", pu_result, 0);
    check("rst_flag", pu_result_flag, 0);
    check("rst_valid", pu_result_valid, 0);
    check("rst_busy", pu_busy, 0);
    check("rst_done", procc_done, 0);
    check("rst_addr_a", pu_address_mem_opa, 0);
    check("rst_addr_b", pu_address_mem_opb, 0);
    pu_reset = 1'b0;
    tick();

    // ADD, 14 pairs, ready held high
    for (int i = 0; i < 14; i++) begin
      ram_a[i] = 32'h11111111 + i * 32'h01010101;
      ram_b[i] = 32'h66611111 + i * 32'h00010101;
    end
    rb = res_q.size(); db = done_cnt; hb = hs_cyc.size();
    start_run(3'b000, 14);
    check("add_e1_busy", pu_busy, 1);
    check("add_e1_valid", pu_result_valid, 0);
    check("add_e1_addr", pu_address_mem_opa, 0);
    tick();
    check("add_e2_valid", pu_result_valid, 0);
    tick();
    check("add_e3_valid", pu_result_valid, 1);
    check("add_e3_result", pu_result, 32'h77722222);
    wait_done("add14", db, 200);
    check("add14_cnt", res_q.size() - rb, 14);
    for (int i = 0; i < 14; i++) begin
      if (rb + i < res_q.size()) begin
        check($sformatf("add14_res%0d", i), res_q[rb + i], 32'h77722222 + i * 32'h01020202);
        check($sformatf("add14_flag%0d", i), flg_q[rb + i], 0);
      end
    end
    check("add14_done_pulses", done_cnt - db, 1);
    if (hs_cyc.size() >= hb + 14) begin
      check("add14_rate", hs_cyc[hb + 1] - hs_cyc[hb], 3);
      check("add14_done_lat", done_cyc - hs_cyc[hb + 13], 1);
    end
    check("add14_idle_busy", pu_busy, 0);

    // Single-pair opcode vectors
`ifdef PROCC_SATURATE_EN
    exp_sub = 32'h00000000;
    exp_add = 32'hFFFFFFFF;
`else
    exp_sub = 32'hFFFFFFFE;
    exp_add = 32'h00000001;
`endif
    run1("sub_5_7", 3'b001, 32'd5, 32'd7, exp_sub, 1'b1);
    run1("add_ovf", 3'b000, 32'hFFFFFFFF, 32'd2, exp_add, 1'b1);
    run1("and", 3'b010, 32'hF0F01234, 32'h0FF05678, 32'h00F01230, 1'b0);
    run1("or",  3'b011, 32'hF0F01234, 32'h0FF05678, 32'hFFF0567C, 1'b0);
    run1("xor", 3'b100, 32'hF0F01234, 32'h0FF05678, 32'hFF00444C, 1'b0);
    run1("min", 3'b101, 32'hF0F01234, 32'h0FF05678, 32'h0FF05678, 1'b0);
    run1("max", 3'b110, 32'hF0F01234, 32'h0FF05678, 32'hF0F01234, 1'b0);
    run1("min_lt", 3'b101, 32'd3, 32'd9, 32'd3, 1'b1);

    // ACC over three pairs
    ram_a[0] = 1; ram_b[0] = 2;
    ram_a[1] = 3; ram_b[1] = 4;
    ram_a[2] = 5; ram_b[2] = 6;
    rb = res_q.size(); db = done_cnt;
    start_run(3'b111, 3);
    wait_done("acc3", db, 50);
    check("acc3_cnt", res_q.size() - rb, 1);
    if (res_q.size() > rb) begin
      check("acc3_res", res_q[rb], 21);
      check("acc3_flag", flg_q[rb], 0);
    end

    // Backpressure with an ignored second start
    ram_a[0] = 32'h10; ram_b[0] = 32'h20;
    ram_a[1] = 32'h30; ram_b[1] = 32'h40;
    pu_result_ready = 1'b0;
    rb = res_q.size(); db = done_cnt;
    start_run(3'b000, 2);
    k = 0;
    while (!pu_result_valid && k < 10) begin
      tick();
      k++;
    end
    check("bp_valid_seen", pu_result_valid, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        procc_start    = 1'b1;
        pu_instruction = 3'b010;
        pu_data_length = 5;
      end else begin
        procc_start = 1'b0;
      end
      tick();
      check($sformatf("bp_valid%0d", i), pu_result_valid, 1);
      check($sformatf("bp_res%0d", i), pu_result, 32'h30);
      check($sformatf("bp_addr%0d", i), pu_address_mem_opa, 0);
    end
    procc_start     = 1'b0;
    pu_result_ready = 1'b1;
    wait_done("bp", db, 50);
    check("bp_cnt", res_q.size() - rb, 2);
    if (res_q.size() >= rb + 2) begin
      check("bp_res0", res_q[rb], 32'h30);
      check("bp_res1", res_q[rb + 1], 32'h70);
    end
    check("bp_done_pulses", done_cnt - db, 1);

    // Length 0
    rb = res_q.size(); db = done_cnt;
    start_run(3'b000, 0);
    check("len0_done_e1", procc_done, 1);
    check("len0_valid_e1", pu_result_valid, 0);
    tick();
    check("len0_done_e2", procc_done, 0);
    check("len0_busy_e2", pu_busy, 0);
    check("len0_no_result", res_q.size() - rb, 0);

    // Reset asserted during LOAD of the fifth pair
    for (int i = 0; i < 14; i++) begin
      ram_a[i] = 32'h11111111 + i * 32'h01010101;
      ram_b[i] = 32'h66611111 + i * 32'h00010101;
    end
    rb = res_q.size(); db = done_cnt;
    start_run(3'b000, 14);
    k = 0;
    while (pu_address_mem_opa != 4 && k < 100) begin
      tick();
      k++;
    end
    check("rstrun_reach_pair5", pu_address_mem_opa, 4);
    tick();
    pu_reset = 1'b1;
    tick();
    check("rstrun_result", pu_result, 0);
    check("rstrun_flag", pu_result_flag, 0);
    check("rstrun_valid", pu_result_valid, 0);
    check("rstrun_busy", pu_busy, 0);
    check("rstrun_done", procc_done, 0);
    check("rstrun_addr", pu_address_mem_opa, 0);
    pu_reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rstrun_no_done", done_cnt - db, 0);
    check("rstrun_results", res_q.size() - rb, 4);

    check("valid_done_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
